// File: rtl/shift_load_bank_pkg.sv
// Shared types and default parameters for the shift/load register bank.
// Contents: command opcode enum, FSM state enum, default lane geometry.
// Imported by shift_load_lane and shift_load_bank.
package shift_load_bank_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 4;

  // Opcode 7 is reserved and has no enumerator; it decodes as NOP.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_SHL   = 3'd3,
    OP_SHR   = 3'd4,
    OP_ROL   = 3'd5,
    OP_ROR   = 3'd6
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_load_lane.sv
// One lane of the bank: one-position shift/rotate result and serial-out select.
// Ports: lane_q (current lane), op (latched op), ser_in (fill bit),
//        lane_shifted (lane after one step), ser_out (MSB, or LSB for SHR).
module shift_load_lane
  import shift_load_bank_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0] lane_q,
  input  op_e               op,
  input  logic              ser_in,
  output logic [LANE_W-1:0] lane_shifted,
  output logic              ser_out
);

  always_comb begin
    lane_shifted = lane_q;
    case (op)
      OP_SHL:  lane_shifted = {lane_q[LANE_W-2:0], ser_in};
      OP_SHR:  lane_shifted = {ser_in, lane_q[LANE_W-1:1]};
      OP_ROL:  lane_shifted = {lane_q[LANE_W-2:0], lane_q[LANE_W-1]};
      OP_ROR:  lane_shifted = {lane_q[0], lane_q[LANE_W-1:1]};
      default: lane_shifted = lane_q;
    endcase
  end

  // The bit that falls off the lane on the next step: LSB for SHR, MSB otherwise.
  assign ser_out = (op == OP_SHR) ? lane_q[0] : lane_q[LANE_W-1];

endmodule

// File: rtl/shift_load_bank.sv
// Multi-lane shift/load register bank: clear, load, multi-cycle shift/rotate.
// Ports: valid/ready command (cmd_op, cmd_amt, load_data, ser_in), q/ser_out
//        data outputs, busy/done status. Optional macro SHIFT_LOAD_BANK_PARITY_EN adds q_par.
module shift_load_bank
  import shift_load_bank_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int CNT_W  = $clog2(LANE_W) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [CNT_W-1:0]        cmd_amt,
  input  logic [LANES*LANE_W-1:0] load_data,
  input  logic [LANES-1:0]        ser_in,
  output logic [LANES*LANE_W-1:0] q,
  output logic [LANES-1:0]        ser_out,
  output logic                    busy,
  output logic                    done
`ifdef SHIFT_LOAD_BANK_PARITY_EN
  ,
  output logic [LANES-1:0]        q_par
`endif
);

  state_e                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  op_e                     op_q, op_d;
  logic [LANES*LANE_W-1:0] q_d, q_shift;
  logic                    done_d, busy_d;
  logic                    accept;
  op_e                     cmd_op_e;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Lanes always compute their one-step result from the latched op; it is
  // only used while in SHIFT.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    shift_load_lane #(.LANE_W(LANE_W)) u_lane (
      .lane_q      (q[l*LANE_W +: LANE_W]),
      .op          (op_q),
      .ser_in      (ser_in[l]),
      .lane_shifted(q_shift[l*LANE_W +: LANE_W]),
      .ser_out     (ser_out[l])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept && is_shift_op(cmd_op_e) && (cmd_amt != '0)) state_d = SHIFT;
      SHIFT: if (cnt == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    q_d    = q;
    cnt_d  = cnt;
    op_d   = op_q;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          case (cmd_op_e)
            OP_CLEAR: q_d = '0;
            OP_LOAD:  q_d = load_data;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
              // amt==0 completes like a NOP; otherwise arm the counter.
              if (cmd_amt != '0) begin
                done_d = 1'b0;
                cnt_d  = cmd_amt;
                op_d   = cmd_op_e;
              end
            end
            default: q_d = q;
          endcase
        end
      end
      SHIFT: begin
        q_d    = q_shift;
        cnt_d  = cnt - CNT_W'(1);
        done_d = (cnt == CNT_W'(1));
      end
      default: q_d = q;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      op_q <= OP_NOP;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      q    <= q_d;
      cnt  <= cnt_d;
      op_q <= op_d;
      done <= done_d;
      busy <= busy_d;
    end
  end

`ifdef SHIFT_LOAD_BANK_PARITY_EN
  // Parity taken from q_d so it lands on the same edge as q.
  logic [LANES-1:0] par_d;
  always_comb begin
    par_d = '0;
    for (int l = 0; l < LANES; l++) par_d[l] = ^q_d[l*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_par <= '0;
    else        q_par <= par_d;
  end
`endif

endmodule
